// File: rtl/jtoutrun_obj_sched.sv
// Object scheduler: hands scanner descriptors to two draw engines and shares the single
// object-ROM port between them, flagging line completion and overruns.
module jtoutrun_obj_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hstart,
  input  logic        scan_req,
  output logic        scan_ack,
  input  logic [49:0] scan_desc,
  input  logic        scan_done,
  output logic        e0_start,
  output logic        e1_start,
  output logic [49:0] e0_desc,
  output logic [49:0] e1_desc,
  input  logic        e0_busy,
  input  logic        e1_busy,
  input  logic        e0_cs,
  input  logic        e1_cs,
  input  logic [17:0] e0_addr,
  input  logic [17:0] e1_addr,
  output logic        e0_ok,
  output logic        e1_ok,
  output logic        obj_cs,
  output logic [17:0] obj_addr,
  input  logic        obj_ok,
  output logic        line_done,
  output logic        late
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t      r_state;
  logic [1:0]  r_pend;
  logic [1:0]  r_start;
  logic [49:0] r_desc0;
  logic [49:0] r_desc1;
  logic        r_line_done;
  logic        r_late;
  logic        r_gnt;
  logic        r_dead;
  logic        r_prev_ok;

  logic [1:0]  w_busy;
  logic [1:0]  w_free;
  logic        w_run;
  logic        w_ack;
  logic        w_tgt;
  logic        w_finish;
  logic        w_outstanding;
  logic        w_own_cs;
  logic        w_oth_cs;
  logic        w_sw;

  // An engine with a start in flight is not free yet: busy only shows two cycles after ack.
  assign w_busy        = {e1_busy, e0_busy};
  assign w_free        = ~w_busy & ~r_pend & ~r_start;
  assign w_run         = (r_state == StRun);
  assign w_ack         = w_run & ~hstart & scan_req & (|w_free);
  assign w_tgt         = ~w_free[0];
  assign w_finish      = w_run & ~hstart & scan_done & ~scan_req & (&w_free);
  assign w_outstanding = (|w_busy) | (|r_pend) | (|r_start) | scan_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pend      <= 2'b00;
      r_start     <= 2'b00;
      r_desc0     <= '0;
      r_desc1     <= '0;
      r_line_done <= 1'b0;
      r_late      <= 1'b0;
    end else begin
      r_start     <= {w_ack & w_tgt, w_ack & ~w_tgt};
      r_line_done <= w_finish;
      r_late      <= hstart & w_run & w_outstanding;
      if (w_ack && !w_tgt) r_desc0 <= scan_desc;
      if (w_ack &&  w_tgt) r_desc1 <= scan_desc;
      if (hstart) begin
        r_state <= StRun;
        r_pend  <= 2'b00;
      end else begin
        r_pend <= r_start | (r_pend & ~w_busy);
        if (w_finish) r_state <= StDone;
      end
    end
  end

  assign scan_ack  = w_ack;
  assign e0_start  = r_start[0];
  assign e1_start  = r_start[1];
  assign e0_desc   = r_desc0;
  assign e1_desc   = r_desc1;
  assign line_done = r_line_done;
  assign late      = r_late;

  // Grant moves to a requesting peer when the owner idles or has just received a word.
  assign w_own_cs = r_gnt ? e1_cs : e0_cs;
  assign w_oth_cs = r_gnt ? e0_cs : e1_cs;
  assign w_sw     = w_oth_cs & (~w_own_cs | r_prev_ok);

  // Dead resets high so the ROM port is quiet for as long as reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= 1'b0;
      r_dead    <= 1'b1;
      r_prev_ok <= 1'b0;
    end else if (hstart) begin
      r_gnt     <= 1'b0;
      r_dead    <= 1'b0;
      r_prev_ok <= 1'b0;
    end else begin
      r_dead    <= w_sw;
      r_prev_ok <= ~w_sw & obj_ok & ~r_dead;
      if (w_sw) r_gnt <= ~r_gnt;
    end
  end

  assign obj_cs   = w_own_cs & ~r_dead;
  assign obj_addr = r_gnt ? e1_addr : e0_addr;
  assign e0_ok    = obj_ok & ~r_gnt & ~r_dead;
  assign e1_ok    = obj_ok & r_gnt & ~r_dead;

endmodule

// File: tb/tb_jtoutrun_obj_sched.sv
// Randomised bench for jtoutrun_obj_sched: a line-level dispatch model feeds a scoreboard
// checked by a monitor, and a grant model checks the ROM port every cycle.
module tb_jtoutrun_obj_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hstart = 1'b0, scan_req = 1'b0, scan_done = 1'b0;
  logic        scan_ack;
  logic [49:0] scan_desc = '0;
  logic        e0_start, e1_start;
  logic [49:0] e0_desc, e1_desc;
  logic        e0_busy = 1'b0, e1_busy = 1'b0, e0_cs = 1'b0, e1_cs = 1'b0;
  logic [17:0] e0_addr = '0, e1_addr = '0;
  logic        e0_ok, e1_ok, obj_cs;
  logic [17:0] obj_addr;
  logic        obj_ok = 1'b0;
  logic        line_done, late;

  always #5 clk = ~clk;

  jtoutrun_obj_sched dut (
    .clk(clk), .rst_n(rst_n), .hstart(hstart), .scan_req(scan_req), .scan_ack(scan_ack),
    .scan_desc(scan_desc), .scan_done(scan_done), .e0_start(e0_start), .e1_start(e1_start),
    .e0_desc(e0_desc), .e1_desc(e1_desc), .e0_busy(e0_busy), .e1_busy(e1_busy),
    .e0_cs(e0_cs), .e1_cs(e1_cs), .e0_addr(e0_addr), .e1_addr(e1_addr), .e0_ok(e0_ok),
    .e1_ok(e1_ok), .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(obj_ok),
    .line_done(line_done), .late(late)
  );

  typedef struct {
    int          tag;
    int          eng;
    logic [49:0] desc;
  } start_t;

  start_t sq[$];
  int     ldq[$];
  int     ltq[$];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Line model: 0 idle, 1 running, 2 done
  int mst = 0;
  bit occ[2];
  int bwait[2];
  int blen[2];
  bit busy[2];
  int dly = 1, lmin = 2, lmax = 6, p_req = 100, line_n = 3, left = 0;
  bit acked = 1'b0;
  // Grant model
  bit g = 1'b0, dead = 1'b0;
  int last = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit hs);
    bit exp_ack, sw;
    bit cs[2];
    int tgt, nlast;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (bwait[i] > 0) begin
        bwait[i]--;
        if (bwait[i] == 0) busy[i] = 1'b1;
      end else if (busy[i]) begin
        blen[i]--;
        if (blen[i] == 0) begin
          busy[i] = 1'b0;
          occ[i]  = 1'b0;
        end
      end
      if ((i == 0) ? e0_start : e1_start) begin
        bwait[i] = dly;
        blen[i]  = $urandom_range(lmax, lmin);
      end
    end
    e0_busy = busy[0];
    e1_busy = busy[1];
    if (hs) left = line_n;
    if (acked) begin
      scan_req = 1'b0;
      acked    = 1'b0;
    end
    if (!scan_req && left > 0 && $urandom_range(99) < p_req) begin
      scan_req  = 1'b1;
      scan_desc = {18'($urandom()), 32'($urandom())};
      left--;
    end
    scan_done = (left == 0) && !scan_req;
    hstart    = hs;
    cs[0]     = ($urandom_range(9) < 6);
    cs[1]     = ($urandom_range(9) < 6);
    e0_cs     = cs[0];
    e1_cs     = cs[1];
    e0_addr   = 18'($urandom());
    e1_addr   = 18'($urandom());
    obj_ok    = ($urandom_range(9) < 4);
    #1;
    exp_ack = (mst == 1) && !hs && scan_req && (!occ[0] || !occ[1]);
    chk("scan_ack", 64'(scan_ack), 64'(exp_ack));
    if (exp_ack) begin
      tgt = occ[0] ? 1 : 0;
      sq.push_back('{cyc, tgt, scan_desc});
      occ[tgt] = 1'b1;
      acked    = 1'b1;
    end
    if (hs) begin
      if (mst == 1 && (occ[0] || occ[1] || busy[0] || busy[1] || scan_req)) ltq.push_back(cyc);
      mst = 1;
      for (int i = 0; i < 2; i++) occ[i] = busy[i] || (bwait[i] > 0);
    end else if (mst == 1 && scan_done && !scan_req && !occ[0] && !occ[1]) begin
      ldq.push_back(cyc);
      mst = 2;
    end
    chk("obj_cs", 64'(obj_cs), 64'(cs[g] && !dead));
    chk("obj_addr", 64'(obj_addr), 64'(g ? e1_addr : e0_addr));
    chk("e0_ok", 64'(e0_ok), 64'(obj_ok && !g && !dead));
    chk("e1_ok", 64'(e1_ok), 64'(obj_ok && g && !dead));
    if (hs) begin
      g    = 1'b0;
      dead = 1'b0;
      last = -1;
    end else begin
      nlast = (obj_ok && !dead) ? int'(g) : -1;
      sw    = cs[!g] && (!cs[g] || last == int'(g));
      dead  = sw;
      if (sw) g = !g;
      last = nlast;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    e0_cs   = 1'b1;
    e1_cs   = 1'b1;
    obj_ok  = 1'b1;
    e0_addr = 18'($urandom());
    e1_addr = 18'($urandom());
    rst_n   = 1'b0;
    #1;
    chk("rst_scan_ack", 64'(scan_ack), 64'(0));
    chk("rst_starts", 64'({e1_start, e0_start}), 64'(0));
    chk("rst_oks", 64'({e1_ok, e0_ok}), 64'(0));
    chk("rst_obj_cs", 64'(obj_cs), 64'(0));
    chk("rst_obj_addr", 64'(obj_addr), 64'(e0_addr));
    chk("rst_e0_desc", 64'(e0_desc), 64'(0));
    chk("rst_e1_desc", 64'(e1_desc), 64'(0));
    chk("rst_pulses", 64'({line_done, late}), 64'(0));
    sq.delete();
    ldq.delete();
    ltq.delete();
    hstart = 1'b0; scan_req = 1'b0; scan_done = 1'b0; e0_busy = 1'b0; e1_busy = 1'b0;
    e0_cs = 1'b0; e1_cs = 1'b0; obj_ok = 1'b0;
    mst = 0; left = 0; acked = 1'b0;
    for (int i = 0; i < 2; i++) begin
      occ[i] = 1'b0; bwait[i] = 0; blen[i] = 0; busy[i] = 1'b0;
    end
    // The first edge after release sees no requests, so the quiet cycle ends there.
    g = 1'b0; dead = 1'b0; last = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares registered pulses against what the model scheduled for this cycle.
  initial begin
    start_t e;
    bit     exp_p;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (sq.size() > 0 && sq[0].tag == cyc) begin
          e = sq.pop_front();
          chk("start_eng", 64'({e1_start, e0_start}), 64'((e.eng == 0) ? 1 : 2));
          chk("start_desc", 64'((e.eng == 0) ? e0_desc : e1_desc), 64'(e.desc));
        end else begin
          chk("start_idle", 64'({e1_start, e0_start}), 64'(0));
        end
        exp_p = (ldq.size() > 0 && ldq[0] == cyc);
        if (exp_p) void'(ldq.pop_front());
        chk("line_done", 64'(line_done), 64'(exp_p));
        exp_p = (ltq.size() > 0 && ltq[0] == cyc);
        if (exp_p) void'(ltq.pop_front());
        chk("late", 64'(late), 64'(exp_p));
      end
    end
  end

  initial begin
    do_reset();
    // Three back-to-back descriptors onto idle engines with long draws.
    dly = 1; lmin = 8; lmax = 8; p_req = 100; line_n = 3;
    step(1);
    repeat (40) step(0);
    // Busy lags start by an extra cycle: the pend mask must hold the engine.
    dly = 2; lmin = 1; lmax = 3; line_n = 6;
    step(1);
    repeat (60) step(0);
    // Abort a line while both engines are drawing.
    dly = 1; lmin = 20; lmax = 20; line_n = 2;
    step(1);
    repeat (6) step(0);
    step(1);
    repeat (40) step(0);
    // Random lines, random hstart, random draw lengths.
    lmin = 1; lmax = 10; p_req = 60;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) dly = $urandom_range(2, 1);
      line_n = $urandom_range(12);
      step($urandom_range(149) == 0 || n == 0);
    end
    do_reset();
    line_n = 5;
    step(1);
    repeat (300) step($urandom_range(99) == 0);
    repeat (30) step(0);
    chk("sb_empty", 64'(sq.size() + ldq.size() + ltq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/jtoutrun_obj_sched.md
# jtoutrun_obj_sched

Dispatches per-line sprite descriptors from the object scanner to two parallel object draw engines and arbitrates the single object-ROM SDRAM port between them. It sits between the scan stage and the draw engines in the object pipeline, and its handshakes match the draw engines' start/busy and cs/ok conventions. It also reports line completion and line overruns.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  pixel-domain clock
- `rst_n`  in  1  reset; asynchronous and active-low
- `hstart`  in  1  line start pulse; aborts the current line
- `scan_req`  in  1  descriptor valid from scanner
- `scan_ack`  out  1  descriptor accepted (combinational)
- `scan_desc`  in  50  {xpos[49:41], offset[40:25], bank[24:22], prio[21:20], shadow[19], pal[18:12], hzoom[11:2], hflip[1], backwd[0]}
- `scan_done`  in  1  level; scanner has no more descriptors for this line
- `e0_start`, `e1_start`  out  1  one-cycle start pulse to each engine
- `e0_desc`, `e1_desc`  out  50  registered descriptor per engine; held until next start
- `e0_busy`, `e1_busy`  in  1  engine busy; rises the cycle after start
- `e0_cs`, `e1_cs`  in  1  engine ROM request
- `e0_addr`, `e1_addr`  in  18  engine ROM word address [19:2]
- `e0_ok`, `e1_ok`  out  1  data valid, gated to the grant owner
- `obj_cs`  out  1  SDRAM request
- `obj_addr`  out  18  SDRAM word address
- `obj_ok`  in  1  SDRAM data valid; `obj_data` goes directly to both engines
- `line_done`  out  1  one-cycle pulse when the line is complete
- `late`  out  1  one-cycle pulse when `hstart` arrives with work outstanding

## Operation
Dispatch FSM, states IDLE, RUN and DONE:
- Reset state is IDLE. `hstart` forces RUN from any state, clears all pending masks, and clears the grant to engine 0.
- Engine i is free when `!ei_busy` and `!pend[i]`. `pend[i]` sets on `ei_start` and clears when `ei_busy` is seen high. This covers the one-cycle busy latency.
- In RUN, `scan_ack = scan_req & (free0 | free1)`. The target is engine 0 if it is free, otherwise engine 1.
- On ack, the target's `ei_desc` is loaded with `scan_desc`. `ei_start` pulses on the next cycle, and that engine's pend bit sets.
- RUN goes to DONE when `scan_done` is high, no `scan_req` is pending, and both engines are free with no start in flight. On that transition `line_done` pulses once.
- DONE holds until `hstart`. In IDLE and DONE, `scan_ack` is 0.
- If `hstart` arrives while in RUN with any engine busy, pending, or `scan_req` high, `late` pulses. `line_done` does not pulse for the aborted line.

ROM arbiter:
- `gnt` is 1 bit. `obj_cs = cs[gnt] & !dead` and `obj_addr = addr[gnt]`.
- `ei_ok = obj_ok & (gnt==i) & !dead`.
- `gnt` switches to the other engine only when that engine's cs is high and one of these holds:
  - the owner's cs is low, or
  - `obj_ok` was high for the owner in the previous cycle (fairness after each delivered word).
- The cycle after a switch is a dead cycle. `obj_cs` and both `ei_ok` are 0 so the SDRAM sees a fresh request.
- Both cs rising together with the owner's cs low: the current owner keeps the grant.

## Timing
- Reset values: `scan_ack`, `e0_start`, `e1_start`, `e0_ok`, `e1_ok`, `obj_cs`, `line_done` and `late` are 0; `obj_addr` is `e0_addr`; `e0_desc` and `e1_desc` are 0; `gnt` is 0; state is IDLE.
- Latency from ack to `ei_start` is 1 cycle. The engine's busy follows at +2.
- A start and an ack to the same engine never happen on consecutive cycles.
- A simultaneous `hstart` and `scan_req` is not acked, and pend bits clear.
- `hstart` mid-switch cancels the dead cycle.
- `rst_n` low mid-line returns everything to reset values immediately.

## Test plan
- Reset, then `hstart`, then 3 back-to-back `scan_req` with both engines idle. Expect: desc 0 goes to e0 and e1_start follows 1 cycle after e0_start. Desc 2 is not acked until an engine's busy falls.
- `e0_busy` held low 1 cycle after `e0_start`. Expect: no second ack to e0 that cycle (pend mask).
- Both cs high, `obj_ok` pulses for e0. Expect: `gnt` goes to 1 with one dead cycle (`obj_cs`=0), then `obj_addr`=`e1_addr`, and `e0_ok` is never asserted while `gnt`=1.
- `scan_done` high with engines draining. Expect: `line_done` exactly 1 cycle after the last busy falls, and the FSM sits in DONE with `scan_ack`=0.
- `hstart` while e1 busy. Expect: `late`=1 for 1 cycle, no `line_done`, pend cleared, `gnt`=0.
- `rst_n` asserted mid-fetch. Expect: `obj_cs`=0 immediately, and all outputs at reset values.
